// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter, next-PC selection and fetch control for the single-cycle CPU
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES  = 128,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Stall,
  input  logic [1:0]  PCSrc,
  input  logic [15:0] Imm16,
  input  logic [25:0] JTarget,
  input  logic [31:0] RegTarget,
  input  logic [31:0] Iout,
  output logic [31:0] Addr,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic        Halted,
  output logic        Fault,
  output logic [31:0] FaultAddr,
  output logic [31:0] CycleCount,
  output logic [31:0] InstrCount
);

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_HALT  = 2'b01;
  localparam logic [1:0] ST_FAULT = 2'b10;

  // Highest word address that may legally be fetched.
  localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - 32'd4);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_fault_addr;
  logic [31:0] r_cycle_count;
  logic [31:0] r_instr_count;

  logic [31:0] w_pc4;
  logic [31:0] w_npc;
  logic [31:0] w_branch_off;
  logic        w_illegal;
  logic        w_run;
  logic        w_retire;
  logic        w_halt_op;

  assign w_pc4        = r_pc + 32'd4;
  assign w_branch_off = {{14{Imm16[15]}}, Imm16, 2'b00};
  assign w_run        = (r_state == ST_RUN);
  assign w_retire     = w_run && !Stall;
  assign w_halt_op    = (Iout[31:26] == HALT_OPCODE);

  // Next-PC candidate from this cycle's control inputs, plus its legality.
  always_comb begin
    w_npc = w_pc4;
    case (PCSrc)
      2'b01:   w_npc = w_pc4 + w_branch_off;
      2'b10:   w_npc = {w_pc4[31:28], JTarget, 2'b00};
      2'b11:   w_npc = RegTarget;
      default: w_npc = w_pc4;
    endcase
    // Wrapped or out-of-range targets both land above LAST_ADDR.
    w_illegal = (w_npc[1:0] != 2'b00) || (w_npc > LAST_ADDR);
  end

  // PC, run/halt/fault state, fault address and counters.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state       <= ST_RUN;
      r_pc          <= RESET_PC;
      r_fault_addr  <= 32'd0;
      r_cycle_count <= 32'd0;
      r_instr_count <= 32'd0;
    end else if (w_run) begin
      r_cycle_count <= r_cycle_count + 32'd1;
      if (!Stall) begin
        r_instr_count <= r_instr_count + 32'd1;
        // Halt outranks any redirect; PC stays on the halt instruction.
        if (w_halt_op) begin
          r_state <= ST_HALT;
        end else if (w_illegal) begin
          r_state      <= ST_FAULT;
          r_fault_addr <= w_npc;
        end else begin
          r_pc <= w_npc;
        end
      end
    end
  end

  assign Addr       = r_pc;
  assign PC         = r_pc;
  assign PC4        = w_pc4;
  assign InstrValid = w_retire;
  assign Instr      = w_retire ? Iout : 32'h0000_0000;
  assign Halted     = (r_state == ST_HALT);
  assign Fault      = (r_state == ST_FAULT);
  assign FaultAddr  = r_fault_addr;
  assign CycleCount = r_cycle_count;
  assign InstrCount = r_instr_count;

endmodule
